sprite_fetch_arbiter: RTL and testbench
=======================================

# sprite_fetch_arbiter

Shares the single synchronous-read `sprites_rom` among `NUM_REQ` reel renderers. Each reel renderer requests one pixel at a time by symbol and coordinate. The block round-robin arbitrates, forms the 17-bit ROM address, tracks the one-cycle ROM read latency and returns the 24-bit pixel to the winning requester. It sits between the per-reel draw logic and `sprites_rom`, and is the only driver of the ROM address.

## Interface
- `NUM_REQ`, 3: number of requesters (reels).
- `SPRITE_W`, 128: sprite width in pixels; must be a power of two.
- `SPRITE_H`, 128: sprite height in pixels; must be a power of two.
- `NUM_SPRITES`, 8: number of sprites loaded in the ROM; symbols at or above this value are unloaded.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request; held with its arguments until granted.
- `req_sym`  in  4*NUM_REQ  symbol index, slice i for requester i.
- `req_x`  in  7*NUM_REQ  pixel column, 0..127.
- `req_y`  in  7*NUM_REQ  pixel row, 0..127.
- `gnt`  out  NUM_REQ  combinational one-hot grant; a transfer occurs at the edge where `req[i] & gnt[i]`.
- `rom_addr`  out  17  registered address to `sprites_rom.addr`.
- `rom_pixel`  in  24  from `sprites_rom.pixel`.
- `rsp_valid`  out  NUM_REQ  registered one-hot; pulses for one cycle per transfer.
- `rsp_pixel`  out  24  registered pixel; meaningful only while `rsp_valid` is non-zero.

## Operation
- **Arbitration**
  - Round-robin with a pointer `last` holding the most recently granted index; reset value is NUM_REQ-1, so requester 0 has priority first.
  - Search starts at last+1 and wraps modulo NUM_REQ.
  - `gnt` is zero when `req` is zero. At most one `gnt` bit is high in any cycle.
  - `last` updates only on a transfer.
- **Address**
  - rom_addr = sym*SPRITE_W*SPRITE_H + y*SPRITE_W + x, equivalent to the concatenation {sym[2:0], y[6:0], x[6:0]}.
  - No carries; x and y are never range-checked because their width enforces the range.
- **Unloaded symbol** (sym ≥ NUM_SPRITES, e.g. 8 = GRAPE)
  - The transfer is still accepted and `rom_addr` holds its previous value.
  - The response is returned with pixel 24'h000000 (transparent).
- **Pipeline**
  - Two stages carry {one-hot owner, blank flag}:
    - S1: loaded at the transfer edge together with `rom_addr`.
    - S2: loaded at the next edge, when the ROM captures `rom_pixel`.
  - The output registers take S2 plus the mux of `rom_pixel` or zero.
- **Reset**
  - `rom_addr`=0, `rsp_valid`=0, `rsp_pixel`=0, pipeline valids=0, `last`=NUM_REQ-1.
  - `gnt` is forced to 0 while `rst` is high.
- **Reset mid-operation:** in-flight requests are discarded with no response. A requester must re-issue after reset.
- **Simultaneous events:** new transfers and in-flight responses proceed independently. Full throughput is one transfer per cycle, and the pipeline never stalls.

## Timing
- Transfer at edge E0 → ROM samples `rom_addr` at E1 → `rsp_valid`/`rsp_pixel` registered at E2. The response is visible in the cycle after E2, a 2-cycle latency.
- Back-to-back transfers at consecutive edges produce responses on consecutive cycles, in grant order.
- `gnt` depends combinationally on `req` and `last` only. It has no path from `req_sym`, `req_x` or `req_y`.
- A requester holding `req` after its transfer is re-arbitrated normally. It is granted again only after the other active requesters have each been served once.

## Structure
- Shared package `sprite_pkg` contains:
  - `SPRITE_W`, `SPRITE_H`, `NUM_SPRITES` and `SPRITE_ADDR_W`=17.
  - Symbol enum: CLOVER=0, WATERMELON=1, BELL=2, BAR=3, CHERRY=4, DIAMOND=5, SEVEN=6, ORANGE=7, GRAPE=8. This enum is shared with the reel and payout logic.
- One sub-module, `rr_arbiter`, parameterised by N.
  - Ports: `clk`, `rst`, `req`, `advance` (transfer strobe), `gnt`.
  - Holds the `last` pointer.
- Address formation, the pipeline and response registers live in the top level.

## Test plan
- **Single request:** requester 1 requests sym 2 (BELL), x=5, y=3.
  - `gnt`=3'b010 that cycle; `rom_addr`=17'h08185 after the edge.
  - `rsp_valid`=3'b010 with the ROM word at 0x08185 exactly 2 cycles after the transfer.
- **All three requesting continuously from reset:**
  - Grants go 0,1,2,0,1,2 on consecutive cycles.
  - Responses follow in the same order, one per cycle, each 2 cycles behind its grant.
- **Corner address:** sym 6 (SEVEN), x=127, y=127 → `rom_addr`=17'h1BFFF. Sym 0, x=0, y=0 → 17'h00000.
- **Unloaded symbol:** sym 8 → transfer accepted, `rom_addr` unchanged, `rsp_pixel`=24'h000000 with `rsp_valid` set on schedule.
- **Rotation with a gap:** requester 2 alone is granted, then requesters 0 and 2 request together → requester 0 is granted first, then 2.
- **Reset mid-flight:** `rst` asserted the cycle after a transfer.
  - No `rsp_valid` ever appears for that transfer.
  - All outputs are 0 the cycle after reset.
  - `last`=2, so the next grant goes to requester 0 when all three request.

Source files
------------

// File: rtl/sprite_pkg.sv
// Sprite geometry and symbol encoding shared by the reel, payout and
// sprite fetch logic.
package sprite_pkg;

    localparam int SPRITE_W      = 128;
    localparam int SPRITE_H      = 128;
    localparam int NUM_SPRITES   = 8;
    localparam int SPRITE_ADDR_W = 17;

    // Reel symbols; GRAPE has no artwork in the ROM and renders transparent.
    typedef enum logic [3:0] {
        CLOVER     = 4'd0,
        WATERMELON = 4'd1,
        BELL       = 4'd2,
        BAR        = 4'd3,
        CHERRY     = 4'd4,
        DIAMOND    = 4'd5,
        SEVEN      = 4'd6,
        ORANGE     = 4'd7,
        GRAPE      = 4'd8
    } symbol_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the most recently granted
// requester and wraps, so every active requester is served once per round.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] win;
    logic          found;

    // Pick the first requester after last, modulo N; no grant while in reset.
    always_comb begin
        gnt   = '0;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && !rst && req[IW'((int'(last) + k) % N)]) begin
                found = 1'b1;
                win   = IW'((int'(last) + k) % N);
            end
        end
        if (found) begin
            gnt[win] = 1'b1;
        end
    end

    // The pointer moves only when a grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= IW'(N - 1);
        end else if (advance && found) begin
            last <= win;
        end
    end

endmodule

// File: rtl/sprite_fetch_arbiter.sv
// Shares the single synchronous-read sprite ROM among the reel renderers:
// arbitrates, forms the ROM address and routes the pixel back to its owner
// two cycles after the transfer.
module sprite_fetch_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int SPRITE_W    = sprite_pkg::SPRITE_W,
    parameter int SPRITE_H    = sprite_pkg::SPRITE_H,
    parameter int NUM_SPRITES = sprite_pkg::NUM_SPRITES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [4*NUM_REQ-1:0] req_sym,
    input  logic [7*NUM_REQ-1:0] req_x,
    input  logic [7*NUM_REQ-1:0] req_y,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [16:0]          rom_addr,
    input  logic [23:0]          rom_pixel,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [23:0]          rsp_pixel
);

    import sprite_pkg::*;

    localparam int XW = $clog2(SPRITE_W);
    localparam int YW = $clog2(SPRITE_H);

    // Power-of-two sprite sizes turn sym*W*H + y*W + x into plain bit fields.
    function automatic logic [SPRITE_ADDR_W-1:0] form_addr(input logic [3:0] sym,
                                                           input logic [6:0] y,
                                                           input logic [6:0] x);
        return (SPRITE_ADDR_W'(sym) << (XW + YW)) | (SPRITE_ADDR_W'(y) << XW) | SPRITE_ADDR_W'(x);
    endfunction

    // Unloaded symbols and idle cycles return transparent black.
    function automatic logic [23:0] pick_pixel(input logic keep, input logic [23:0] pix);
        return keep ? pix : 24'h000000;
    endfunction

    logic               xfer;
    logic [3:0]         sel_sym;
    logic [6:0]         sel_x;
    logic [6:0]         sel_y;
    logic               sel_blank;

    logic               vld_p1;
    logic [NUM_REQ-1:0] own_p1;
    logic               blank_p1;
    logic               vld_p2;
    logic [NUM_REQ-1:0] own_p2;
    logic               blank_p2;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (xfer),
        .gnt     (gnt)
    );

    assign xfer      = |(req & gnt);
    assign sel_blank = int'(sel_sym) >= NUM_SPRITES;

    // Route the granted requester's symbol and coordinates to the address path.
    always_comb begin
        sel_sym = '0;
        sel_x   = '0;
        sel_y   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_sym = req_sym[4*i +: 4];
                sel_x   = req_x[7*i +: 7];
                sel_y   = req_y[7*i +: 7];
            end
        end
    end

    // ---- S1: transfer edge; address to the ROM, owner and blank flag tracked ----
    // An unloaded symbol keeps the old address; its pixel is discarded anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            own_p1   <= '0;
            blank_p1 <= 1'b0;
            rom_addr <= '0;
        end else begin
            vld_p1   <= xfer;
            own_p1   <= req & gnt;
            blank_p1 <= sel_blank;
            if (xfer && !sel_blank) begin
                rom_addr <= form_addr(sel_sym, sel_y, sel_x);
            end
        end
    end

    // ---- S2: ROM captures rom_addr; owner moves alongside the read ----
    // Tag follows the ROM's one-cycle read so it lines up with rom_pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            own_p2   <= '0;
            blank_p2 <= 1'b0;
        end else begin
            vld_p2   <= vld_p1;
            own_p2   <= own_p1;
            blank_p2 <= blank_p1;
        end
    end

    // ---- Output: pixel and one-hot owner registered together ----
    // Response registers: one pulse per transfer, pixel zeroed for blanks.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_pixel <= '0;
        end else begin
            rsp_valid <= vld_p2 ? own_p2 : '0;
            rsp_pixel <= pick_pixel(vld_p2 && !blank_p2, rom_pixel);
        end
    end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: a ROM model drives rom_pixel, a reference
// arbiter predicts grants, and expected responses queue up until they are due.
module tb_sprite_fetch_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [11:0] req_sym;
    logic [20:0] req_x;
    logic [20:0] req_y;
    logic [2:0]  gnt;
    logic [16:0] rom_addr;
    logic [23:0] rom_pixel;
    logic [2:0]  rsp_valid;
    logic [23:0] rsp_pixel;

    typedef struct {
        logic [2:0]  own;
        logic [23:0] pix;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          total    = 0;
    int          bad      = 0;
    int          cyc      = 0;
    int          last_m   = 2;
    logic [16:0] exp_addr = '0;
    logic        mon_en   = 1'b0;

    sprite_fetch_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_sym   (req_sym),
        .req_x     (req_x),
        .req_y     (req_y),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_pixel (rom_pixel),
        .rsp_valid (rsp_valid),
        .rsp_pixel (rsp_pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Never zero for any address, so a blanked pixel is distinguishable.
    function automatic logic [23:0] rom_word(input logic [16:0] a);
        return {a[7:0], a[16:1]} ^ 24'h3C5A96;
    endfunction

    // Synchronous-read ROM model.
    always @(posedge clk) rom_pixel <= rom_word(rom_addr);

    function automatic logic [2:0] model_gnt(input logic [2:0] r, input int lst);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (lst + k) % 3;
            if (r[i]) return 3'b001 << i;
        end
        return 3'b000;
    endfunction

    task automatic set_req(input int i, input logic [3:0] s, input logic [6:0] x, input logic [6:0] y);
        req[i]            = 1'b1;
        req_sym[4*i +: 4] = s;
        req_x[7*i +: 7]   = x;
        req_y[7*i +: 7]   = y;
    endtask

    // One clock: predict the transfer, let the edge happen, queue the response.
    task automatic tick();
        logic [2:0]  g;
        logic [3:0]  s;
        logic [16:0] a;
        int          w;
        exp_t        e;
        g = rst ? 3'b000 : model_gnt(req, last_m);
        w = 0;
        for (int i = 0; i < 3; i++) if (g[i]) w = i;
        @(posedge clk);
        cyc++;
        if (rst) begin
            last_m   = 2;
            exp_addr = '0;
            q.delete();
        end else if (g != 3'b000) begin
            s      = req_sym[4*w +: 4];
            a      = {s[2:0], req_y[7*w +: 7], req_x[7*w +: 7]};
            last_m = w;
            e.own  = g;
            e.due  = cyc + 2;
            if (s >= 4'd8) begin
                e.pix = 24'h000000;
            end else begin
                e.pix    = rom_word(a);
                exp_addr = a;
            end
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Scoreboard: each cycle either the oldest expected response is due or
    // rsp_valid must be quiet.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (q.size() != 0 && q[0].due == cyc) begin
                if (rsp_valid !== q[0].own || rsp_pixel !== q[0].pix) begin
                    bad++;
                    $display("FAIL rsp cyc=%0d: got valid=%b pixel=%h, want valid=%b pixel=%h",
                             cyc, rsp_valid, rsp_pixel, q[0].own, q[0].pix);
                end
                void'(q.pop_front());
            end else if (rsp_valid !== 3'b000) begin
                bad++;
                $display("FAIL spurious_rsp cyc=%0d: got valid=%b, want 000", cyc, rsp_valid);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 4'(i + 1), 7'(10 + i), 7'(20 + i));
        #1;
        total++;
        if (gnt !== 3'b000) begin
            bad++; $display("FAIL reset_gnt: got %b want 000", gnt);
        end
        tick();
        tick();
        mon_en = 1'b1;
        total++;
        if (rom_addr !== 17'h00000) begin
            bad++; $display("FAIL reset_addr: got %h want 00000", rom_addr);
        end
        total++;
        if (rsp_valid !== 3'b000 || rsp_pixel !== 24'h000000) begin
            bad++; $display("FAIL reset_rsp: got valid=%b pixel=%h want 000/000000", rsp_valid, rsp_pixel);
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_single();
        set_req(1, 4'd2, 7'd5, 7'd3);
        #1;
        total++;
        if (gnt !== 3'b010) begin
            bad++; $display("FAIL single_gnt: got %b want 010", gnt);
        end
        tick();
        req = '0;
        total++;
        if (rom_addr !== 17'h08185) begin
            bad++; $display("FAIL single_addr: got %h want 08185", rom_addr);
        end
        tick();
        total++;
        if (rsp_valid !== 3'b000) begin
            bad++; $display("FAIL single_early: got valid=%b want 000", rsp_valid);
        end
        tick();
        total++;
        if (rsp_valid !== 3'b010 || rsp_pixel !== rom_word(17'h08185)) begin
            bad++; $display("FAIL single_rsp: got valid=%b pixel=%h want 010/%h",
                            rsp_valid, rsp_pixel, rom_word(17'h08185));
        end
    endtask

    task automatic test_round_robin();
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            set_req(i, 4'(i + 3), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        for (int k = 0; k < 6; k++) begin
            #1;
            total++;
            if (gnt !== (3'b001 << (k % 3))) begin
                bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, 3'b001 << (k % 3));
            end
            tick();
            total++;
            if (rom_addr !== exp_addr) begin
                bad++; $display("FAIL rr_addr[%0d]: got %h want %h", k, rom_addr, exp_addr);
            end
            set_req(k % 3, 4'((k + 1) % 8), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_corner();
        set_req(0, 4'd6, 7'd127, 7'd127);
        tick();
        req = '0;
        total++;
        if (rom_addr !== 17'h1BFFF) begin
            bad++; $display("FAIL corner_max: got %h want 1BFFF", rom_addr);
        end
        set_req(2, 4'd0, 7'd0, 7'd0);
        tick();
        req = '0;
        total++;
        if (rom_addr !== 17'h00000) begin
            bad++; $display("FAIL corner_zero: got %h want 00000", rom_addr);
        end
        repeat (3) tick();
    endtask

    task automatic test_unloaded();
        set_req(2, 4'd5, 7'd9, 7'd10);
        tick();
        req = '0;
        total++;
        if (rom_addr !== {3'd5, 7'd10, 7'd9}) begin
            bad++; $display("FAIL unl_setup: got %h want %h", rom_addr, {3'd5, 7'd10, 7'd9});
        end
        set_req(1, 4'd8, 7'd33, 7'd44);
        #1;
        total++;
        if (gnt !== 3'b010) begin
            bad++; $display("FAIL unl_gnt: got %b want 010", gnt);
        end
        tick();
        req = '0;
        total++;
        if (rom_addr !== {3'd5, 7'd10, 7'd9}) begin
            bad++; $display("FAIL unl_addr_hold: got %h want %h", rom_addr, {3'd5, 7'd10, 7'd9});
        end
        tick();
        tick();
        total++;
        if (rsp_valid !== 3'b010 || rsp_pixel !== 24'h000000) begin
            bad++; $display("FAIL unl_rsp: got valid=%b pixel=%h want 010/000000", rsp_valid, rsp_pixel);
        end
        set_req(0, 4'd15, 7'd1, 7'd2);
        tick();
        req = '0;
        total++;
        if (rom_addr !== {3'd5, 7'd10, 7'd9}) begin
            bad++; $display("FAIL unl15_addr: got %h want %h", rom_addr, {3'd5, 7'd10, 7'd9});
        end
        repeat (3) tick();
    endtask

    task automatic test_gap();
        set_req(2, 4'd1, 7'd2, 7'd3);
        #1;
        total++;
        if (gnt !== 3'b100) begin
            bad++; $display("FAIL gap_first: got %b want 100", gnt);
        end
        tick();
        req = '0;
        tick();
        set_req(0, 4'd4, 7'd40, 7'd50);
        set_req(2, 4'd7, 7'd60, 7'd70);
        #1;
        total++;
        if (gnt !== 3'b001) begin
            bad++; $display("FAIL gap_r0: got %b want 001", gnt);
        end
        tick();
        #1;
        total++;
        if (gnt !== 3'b100) begin
            bad++; $display("FAIL gap_r2: got %b want 100", gnt);
        end
        tick();
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_midflight();
        set_req(0, 4'd3, 7'd1, 7'd1);
        tick();
        req = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (rom_addr !== 17'h0 || rsp_valid !== 3'b000 || rsp_pixel !== 24'h0 || gnt !== 3'b000) begin
            bad++; $display("FAIL midrst_outputs: got addr=%h valid=%b pixel=%h gnt=%b want all zero",
                            rom_addr, rsp_valid, rsp_pixel, gnt);
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) set_req(i, 4'(i), 7'(i + 7), 7'(i + 9));
        #1;
        total++;
        if (gnt !== 3'b001) begin
            bad++; $display("FAIL midrst_gnt: got %b want 001", gnt);
        end
        tick();
        req = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_sym = '0;
        req_x   = '0;
        req_y   = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_corner();
        test_unloaded();
        test_gap();
        test_reset_midflight();
        repeat (4) tick();
        total++;
        if (q.size() != 0) begin
            bad++; $display("FAIL drain: got %0d pending responses want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
